// File: rtl/cpu_phase_sequencer.sv
// cpu_phase_sequencer
//   Timing-phase controller for the CPU control unit. A prescaler divides the
//   system clock, a step counter walks the machine phases and an active-low
//   one-hot decoder drives the phase strobes. Supports free-run, single
//   sequence, halt and preset-step control.
//
// Ports
//   CLK       in   1   system clock, rising edge
//   MR        in   1   master reset, asynchronous, active-low
//   RUN       in   1   level: free-run request
//   STEP      in   1   1-clock pulse: run exactly one full phase sequence
//   HALT_REQ  in   1   level: freeze sequencing at the current phase
//   LOAD_N    in   1   active-low synchronous preset of the step counter
//   D         in   4   preset step value (values >= NUM_PHASES load 0)
//   PHASE_N   out  16  active-low one-hot phase strobes
//   STEP_Q    out  4   current step number
//   TICK      out  1   prescaler terminal count
//   DONE      out  1   pulse in the clock after a NUM_PHASES-1 -> 0 wrap
//   BUSY      out  1   high in RUN or SINGLE
//   STATE     out  2   00 IDLE, 01 RUN, 10 SINGLE, 11 HALTED (debug view of the FSM)
//
// Control inputs are level/pulse qualified at each rising edge with priority
// HALT_REQ > LOAD_N > STEP > RUN; there is no handshake. All outputs come from
// registered state only.
module cpu_phase_sequencer #(
  parameter int PRESCALE_BITS = 2,
  parameter int NUM_PHASES    = 8
) (
  input  logic        CLK,
  input  logic        MR,
  input  logic        RUN,
  input  logic        STEP,
  input  logic        HALT_REQ,
  input  logic        LOAD_N,
  input  logic [3:0]  D,
  output logic [15:0] PHASE_N,
  output logic [3:0]  STEP_Q,
  output logic        TICK,
  output logic        DONE,
  output logic        BUSY,
  output logic [1:0]  STATE
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_SINGLE = 2'b10,
    S_HALTED = 2'b11
  } state_t;

  // A zero-bit prescaler still needs a 1-bit register; it is pinned at 0 and
  // its terminal count is 0, so TICK fires every busy clock.
  localparam int            PW     = (PRESCALE_BITS > 0) ? PRESCALE_BITS : 1;
  localparam logic [PW-1:0] PRE_TC = (PRESCALE_BITS > 0) ? {PW{1'b1}} : '0;
  localparam logic [3:0]    LAST   = 4'(NUM_PHASES - 1);
  localparam logic [4:0]    NP5    = 5'(NUM_PHASES);

  state_t        state, state_nx;
  logic [3:0]    step_cnt, step_nx;
  logic [PW-1:0] pre, pre_nx, pre_inc;
  logic          done_r, done_nx;
  logic          busy, tick;
  logic [3:0]    load_val;

  assign busy     = (state == S_RUN) || (state == S_SINGLE);
  assign tick     = busy && (pre == PRE_TC);
  assign pre_inc  = (PRESCALE_BITS > 0) ? pre + PW'(1) : '0;
  // Out-of-range presets clamp to step 0 so STEP_Q never leaves 0..NUM_PHASES-1.
  assign load_val = ({1'b0, D} >= NP5) ? 4'd0 : D;

  always_ff @(posedge CLK or negedge MR) begin
    if (!MR) begin
      state    <= S_IDLE;
      step_cnt <= 4'd0;
      pre      <= '0;
      done_r   <= 1'b0;
    end else begin
      state    <= state_nx;
      step_cnt <= step_nx;
      pre      <= pre_nx;
      done_r   <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    step_nx  = step_cnt;
    pre_nx   = pre;
    done_nx  = 1'b0;
    case (state)
      S_IDLE: begin
        pre_nx = '0;
        if (HALT_REQ)     state_nx = S_HALTED;
        else if (!LOAD_N) step_nx  = load_val;
        else if (STEP)    state_nx = S_SINGLE;
        else if (RUN)     state_nx = S_RUN;
      end
      S_RUN, S_SINGLE: begin
        if (HALT_REQ) begin
          state_nx = S_HALTED;   // step and prescaler frozen
        end else begin
          pre_nx = pre_inc;
          if (tick) begin
            if (step_cnt == LAST) begin
              step_nx = 4'd0;
              done_nx = 1'b1;
              // RUN is only sampled at the wrap, so dropping it never cuts a sequence short.
              if (state == S_SINGLE || !RUN) state_nx = S_IDLE;
            end else begin
              step_nx = step_cnt + 4'd1;
            end
          end
        end
      end
      S_HALTED: begin
        if (!LOAD_N) begin
          step_nx = load_val;
        end else if (!HALT_REQ) begin
          // Restart the prescaler so the resumed phase gets its full length.
          pre_nx   = '0;
          state_nx = RUN ? S_RUN : S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign PHASE_N = (state == S_IDLE) ? 16'hFFFF : ~(16'h0001 << step_cnt);
  assign STEP_Q  = step_cnt;
  assign TICK    = tick;
  assign DONE    = done_r;
  assign BUSY    = busy;
  assign STATE   = state;

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// tb_cpu_phase_sequencer
//   Bench for cpu_phase_sequencer with PRESCALE_BITS=2, NUM_PHASES=8.
//   Reference model tracks the position (in clocks) inside the machine cycle;
//   step and tick are derived from it arithmetically.
module tb_cpu_phase_sequencer;

  localparam int P  = 4;   // clocks per phase
  localparam int NP = 8;   // phases per machine cycle

  localparam int M_IDLE = 0, M_RUN = 1, M_SINGLE = 2, M_HALTED = 3;

  // ---------------- clock / reset ----------------
  logic clk;
  logic mr;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic        run, step_req, halt, load_n;
  logic [3:0]  d;
  logic [15:0] phase_n;
  logic [3:0]  step_q;
  logic        tick, done, busy;
  logic [1:0]  state;

  cpu_phase_sequencer #(.PRESCALE_BITS(2), .NUM_PHASES(8)) dut (
    .CLK(clk), .MR(mr), .RUN(run), .STEP(step_req), .HALT_REQ(halt),
    .LOAD_N(load_n), .D(d), .PHASE_N(phase_n), .STEP_Q(step_q),
    .TICK(tick), .DONE(done), .BUSY(busy), .STATE(state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_state;
  int m_pos;    // clocks elapsed in the current machine cycle, 0..NP*P-1
  bit m_done;

  function automatic int clampd(input int v);
    return (v >= NP) ? 0 : v;
  endfunction

  task automatic model_reset();
    m_state = M_IDLE;
    m_pos   = 0;
    m_done  = 0;
  endtask

  task automatic model_edge();
    bit was_last;
    m_done = 0;
    case (m_state)
      M_IDLE: begin
        if (halt)             m_state = M_HALTED;
        else if (!load_n)     m_pos   = clampd(int'(d)) * P;
        else if (step_req)    m_state = M_SINGLE;
        else if (run)         m_state = M_RUN;
      end
      M_RUN, M_SINGLE: begin
        if (halt) begin
          m_state = M_HALTED;
        end else begin
          was_last = (m_pos == NP * P - 1);
          m_pos    = (m_pos + 1) % (NP * P);
          if (was_last) begin
            m_done = 1;
            if (m_state == M_SINGLE || !run) m_state = M_IDLE;
          end
        end
      end
      default: begin
        if (!load_n) m_pos = clampd(int'(d)) * P;
        else if (!halt) begin
          m_pos   = (m_pos / P) * P;   // resume at the start of the held phase
          m_state = run ? M_RUN : M_IDLE;
        end
      end
    endcase
  endtask

  task automatic check_all();
    bit          e_busy;
    logic [15:0] e_phase;
    e_busy  = (m_state == M_RUN) || (m_state == M_SINGLE);
    e_phase = (m_state == M_IDLE) ? 16'hFFFF : ~(16'h0001 << (m_pos / P));
    exp_q.push_back(e_phase);
    chk("state",   16'(state),  16'(m_state));
    chk("step_q",  16'(step_q), 16'(m_pos / P));
    chk("phase_n", phase_n,     exp_q.pop_front());
    chk("tick",    16'(tick),   16'(e_busy && (m_pos % P == P - 1)));
    chk("done",    16'(done),   16'(m_done));
    chk("busy",    16'(busy),   16'(e_busy));
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #2;
    check_all();
  endtask

  task automatic do_reset();
    mr = 1'b0;
    #1;
    model_reset();
    check_all();          // reset values must appear without a clock edge
    @(posedge clk);
    #3;
    mr = 1'b1;
    #1;
  endtask

  task automatic idle_inputs();
    run = 0; step_req = 0; halt = 0; load_n = 1; d = 4'd0;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        run, stp, halt, load_n;
    logic [3:0]  d;
    logic [1:0]  e_state;
    logic [3:0]  e_step;
    logic        e_tick;
    logic [15:0] e_phase;
  } vec_t;

  vec_t vecs[16];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, ticks, dones, adv, max_step;
    logic [3:0] prev;

    //            run stp hlt ldn d      state  step  tick phase
    vecs[0]  = '{1'b0,1'b0,1'b0,1'b0,4'd6, 2'd0,4'd6,1'b0,16'hFFFF};
    vecs[1]  = '{1'b0,1'b0,1'b0,1'b0,4'd12,2'd0,4'd0,1'b0,16'hFFFF};
    vecs[2]  = '{1'b0,1'b0,1'b0,1'b0,4'd7, 2'd0,4'd7,1'b0,16'hFFFF};
    vecs[3]  = '{1'b0,1'b0,1'b0,1'b0,4'd8, 2'd0,4'd0,1'b0,16'hFFFF};
    vecs[4]  = '{1'b0,1'b0,1'b1,1'b1,4'd0, 2'd3,4'd0,1'b0,16'hFFFE};
    vecs[5]  = '{1'b0,1'b0,1'b1,1'b0,4'd5, 2'd3,4'd5,1'b0,16'hFFDF};
    vecs[6]  = '{1'b0,1'b0,1'b1,1'b1,4'd0, 2'd3,4'd5,1'b0,16'hFFDF};
    vecs[7]  = '{1'b0,1'b0,1'b0,1'b1,4'd0, 2'd0,4'd5,1'b0,16'hFFFF};
    vecs[8]  = '{1'b0,1'b1,1'b0,1'b0,4'd2, 2'd0,4'd2,1'b0,16'hFFFF};
    vecs[9]  = '{1'b0,1'b1,1'b0,1'b1,4'd0, 2'd2,4'd2,1'b0,16'hFFFB};
    vecs[10] = '{1'b0,1'b0,1'b0,1'b1,4'd0, 2'd2,4'd2,1'b0,16'hFFFB};
    vecs[11] = '{1'b0,1'b0,1'b0,1'b1,4'd0, 2'd2,4'd2,1'b0,16'hFFFB};
    vecs[12] = '{1'b0,1'b0,1'b0,1'b1,4'd0, 2'd2,4'd2,1'b1,16'hFFFB};
    vecs[13] = '{1'b1,1'b0,1'b0,1'b0,4'd1, 2'd2,4'd3,1'b0,16'hFFF7};
    vecs[14] = '{1'b0,1'b0,1'b1,1'b1,4'd0, 2'd3,4'd3,1'b0,16'hFFF7};
    vecs[15] = '{1'b1,1'b0,1'b0,1'b1,4'd0, 2'd1,4'd3,1'b0,16'hFFF7};

    idle_inputs();
    do_reset();

    for (int i = 0; i < 16; i++) begin
      run = vecs[i].run; step_req = vecs[i].stp; halt = vecs[i].halt;
      load_n = vecs[i].load_n; d = vecs[i].d;
      cycle();
      chk($sformatf("vec%0d_state", i), 16'(state),  16'(vecs[i].e_state));
      chk($sformatf("vec%0d_step", i),  16'(step_q), 16'(vecs[i].e_step));
      chk($sformatf("vec%0d_tick", i),  16'(tick),   16'(vecs[i].e_tick));
      chk($sformatf("vec%0d_phase", i), phase_n,     vecs[i].e_phase);
    end

    // free run: TICK every 4th clock, one DONE per 32 clocks
    idle_inputs();
    do_reset();
    run = 1;
    ticks = 0; dones = 0;
    repeat (40) begin
      cycle();
      if (tick) ticks++;
      if (done) dones++;
    end
    chk("run40_ticks", 16'(ticks), 16'd10);
    chk("run40_dones", 16'(dones), 16'd1);

    // single sequence from IDLE
    idle_inputs();
    do_reset();
    step_req = 1;
    cycle();
    step_req = 0;
    adv = 0; dones = 0; prev = step_q;
    n = 0;
    while (n < 100 && state != 2'b00) begin
      cycle();
      if (step_q != prev) adv++;
      prev = step_q;
      if (done) dones++;
      n++;
    end
    chk("single_advances", 16'(adv), 16'd8);
    chk("single_dones", 16'(dones), 16'd1);
    chk("single_end_state", 16'(state), 16'd0);
    chk("single_end_phase", phase_n, 16'hFFFF);

    // RUN dropped at step 3 finishes the sequence
    idle_inputs();
    do_reset();
    run = 1;
    n = 0;
    while (n < 100 && step_q != 4'd3) begin cycle(); n++; end
    run = 0;
    max_step = int'(step_q); dones = 0; n = 0;
    while (n < 100 && state != 2'b00) begin
      cycle();
      if (int'(step_q) > max_step) max_step = int'(step_q);
      if (done) dones++;
      n++;
    end
    chk("drop_max_step", 16'(max_step), 16'd7);
    chk("drop_dones", 16'(dones), 16'd1);
    chk("drop_state", 16'(state), 16'd0);

    // halt at step 5, then resume
    idle_inputs();
    do_reset();
    run = 1;
    n = 0;
    while (n < 100 && step_q != 4'd5) begin cycle(); n++; end
    halt = 1;
    repeat (10) begin
      cycle();
      chk("halt_step", 16'(step_q), 16'd5);
      chk("halt_phase", phase_n, 16'hFFDF);
      chk("halt_tick", 16'(tick), 16'd0);
    end
    halt = 0;
    n = 0;
    do begin cycle(); n++; end while (!tick && n < 20);
    chk("resume_tick_latency", 16'(n), 16'd4);

    // asynchronous reset mid-sequence at step 4
    idle_inputs();
    do_reset();
    run = 1;
    n = 0;
    while (n < 100 && step_q != 4'd4) begin cycle(); n++; end
    #3;
    do_reset();
    run = 0;
    cycle();
    chk("after_mr_state", 16'(state), 16'd0);

    // randomized stimulus against the model
    idle_inputs();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      run      = ($urandom_range(0, 3) != 0);
      step_req = ($urandom_range(0, 9) == 0);
      halt     = ($urandom_range(0, 15) == 0);
      load_n   = ($urandom_range(0, 11) != 0);
      d        = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 199) == 0) begin
        #3;
        do_reset();
      end else begin
        cycle();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
